network_bf_out: RTL and testbench

//  Write-back network for the radix-2 dual-butterfly NTT datapath. Routes the two butterfly

---
 rtl/network_bf_out.sv | 167 ++++++++++++++++
 tb/tb_network_bf_out.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/network_bf_out.sv
// Write-back network for the dual-butterfly NTT datapath: a BF_LAT-deep command pipe carries the
// per-bank routing so it lines up with the butterfly results, then one registered output stage.
module network_bf_out #(
    parameter int unsigned data_width = 14,
    parameter int unsigned addr_width = 8,
    parameter int unsigned BF_LAT     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic                  last,
    input  logic [1:0]            sel_b_0,
    input  logic [1:0]            sel_b_1,
    input  logic [1:0]            sel_b_2,
    input  logic [1:0]            sel_b_3,
    input  logic [3:0]            wen_mask,
    input  logic [addr_width-1:0] waddr_0,
    input  logic [addr_width-1:0] waddr_1,
    input  logic [addr_width-1:0] waddr_2,
    input  logic [addr_width-1:0] waddr_3,
    input  logic [data_width-1:0] x0,
    input  logic [data_width-1:0] y0,
    input  logic [data_width-1:0] x1,
    input  logic [data_width-1:0] y1,
    output logic [data_width-1:0] d0,
    output logic [data_width-1:0] d1,
    output logic [data_width-1:0] d2,
    output logic [data_width-1:0] d3,
    output logic [addr_width-1:0] wa0,
    output logic [addr_width-1:0] wa1,
    output logic [addr_width-1:0] wa2,
    output logic [addr_width-1:0] wa3,
    output logic [3:0]            we,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  dup_err
);

    localparam int unsigned CNT_W = $clog2(BF_LAT + 2);
    localparam int unsigned MUX   = BF_LAT - 1;

    logic [BF_LAT-1:0]     vld_q, vld_d, last_q, last_d;
    logic [1:0]            sel_q  [BF_LAT][4];
    logic [1:0]            sel_d  [BF_LAT][4];
    logic [3:0]            mask_q [BF_LAT];
    logic [3:0]            mask_d [BF_LAT];
    logic [addr_width-1:0] addr_q [BF_LAT][4];
    logic [addr_width-1:0] addr_d [BF_LAT][4];

    logic [data_width-1:0] dat_q [4];
    logic [data_width-1:0] dat_d [4];
    logic [addr_width-1:0] wa_q  [4];
    logic [addr_width-1:0] wa_d  [4];
    logic [3:0]            we_q, we_d;
    logic                  out_vld_q, out_vld_d;
    logic                  stage_done_q, stage_done_d;
    logic                  dup_err_q, dup_err_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      in_flight_q, in_flight_d;

    logic [data_width-1:0] src [4];
    logic                  dup;

    // Command pipe shift: stage 0 captures the issuing command.
    always_comb begin
        vld_d     = vld_q;
        last_d    = last_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        vld_d[0]  = issue;
        last_d[0] = issue & last;
        sel_d[0]  = '{sel_b_0, sel_b_1, sel_b_2, sel_b_3};
        mask_d[0] = wen_mask;
        addr_d[0] = '{waddr_0, waddr_1, waddr_2, waddr_3};
        for (int s = 1; s < int'(BF_LAT); s++) begin
            vld_d[s]  = vld_q[s-1];
            last_d[s] = last_q[s-1];
            sel_d[s]  = sel_q[s-1];
            mask_d[s] = mask_q[s-1];
            addr_d[s] = addr_q[s-1];
        end
    end

    // Mux stage routing, duplicate detection and in-flight accounting.
    always_comb begin
        src          = '{x0, y0, x1, y1};
        dat_d        = dat_q;
        wa_d         = wa_q;
        we_d         = 4'b0000;
        dup          = 1'b0;
        out_vld_d    = vld_q[MUX];
        stage_done_d = vld_q[MUX] & last_q[MUX];
        in_flight_d  = in_flight_q;
        for (int b = 0; b < 4; b++) begin
            if (vld_q[MUX] && mask_q[MUX][b]) begin
                dat_d[b] = src[sel_q[MUX][b]];
                wa_d[b]  = addr_q[MUX][b];
                we_d[b]  = 1'b1;
            end
            for (int c = b + 1; c < 4; c++) begin
                if (mask_q[MUX][b] && mask_q[MUX][c] && (sel_q[MUX][b] == sel_q[MUX][c])) begin
                    dup = 1'b1;
                end
            end
        end
        dup_err_d = dup_err_q | (vld_q[MUX] & dup);
        case ({issue, out_vld_q})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
        busy_d = (in_flight_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q        <= '0;
            last_q       <= '0;
            for (int s = 0; s < int'(BF_LAT); s++) begin
                mask_q[s] <= '0;
                for (int b = 0; b < 4; b++) begin
                    sel_q[s][b]  <= '0;
                    addr_q[s][b] <= '0;
                end
            end
            for (int b = 0; b < 4; b++) begin
                dat_q[b] <= '0;
                wa_q[b]  <= '0;
            end
            we_q         <= '0;
            out_vld_q    <= 1'b0;
            stage_done_q <= 1'b0;
            dup_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            in_flight_q  <= '0;
        end else begin
            vld_q        <= vld_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            dat_q        <= dat_d;
            wa_q         <= wa_d;
            we_q         <= we_d;
            out_vld_q    <= out_vld_d;
            stage_done_q <= stage_done_d;
            dup_err_q    <= dup_err_d;
            busy_q       <= busy_d;
            in_flight_q  <= in_flight_d;
        end
    end

    assign d0         = dat_q[0];
    assign d1         = dat_q[1];
    assign d2         = dat_q[2];
    assign d3         = dat_q[3];
    assign wa0        = wa_q[0];
    assign wa1        = wa_q[1];
    assign wa2        = wa_q[2];
    assign wa3        = wa_q[3];
    assign we         = we_q;
    assign busy       = busy_q;
    assign stage_done = stage_done_q;
    assign dup_err    = dup_err_q;

endmodule

// File: tb/tb_network_bf_out.sv
// Directed bench for network_bf_out with hand-computed expectations (BF_LAT=4).
module tb_network_bf_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue, last;
    logic [1:0]  sel_b_0, sel_b_1, sel_b_2, sel_b_3;
    logic [3:0]  wen_mask;
    logic [7:0]  waddr_0, waddr_1, waddr_2, waddr_3;
    logic [13:0] x0, y0, x1, y1;
    logic [13:0] d0, d1, d2, d3;
    logic [7:0]  wa0, wa1, wa2, wa3;
    logic [3:0]  we;
    logic        busy, stage_done, dup_err;

    int errors = 0;
    int checks = 0;
    logic [3:0] we_seen;

    network_bf_out #(.data_width(14), .addr_width(8), .BF_LAT(4)) dut (
        .clk(clk), .rst(rst), .issue(issue), .last(last),
        .sel_b_0(sel_b_0), .sel_b_1(sel_b_1), .sel_b_2(sel_b_2), .sel_b_3(sel_b_3),
        .wen_mask(wen_mask),
        .waddr_0(waddr_0), .waddr_1(waddr_1), .waddr_2(waddr_2), .waddr_3(waddr_3),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3),
        .we(we), .busy(busy), .stage_done(stage_done), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic iss, input logic lst,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] s3,
                       input logic [3:0] m,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3);
        issue = iss; last = lst;
        sel_b_0 = s0; sel_b_1 = s1; sel_b_2 = s2; sel_b_3 = s3;
        wen_mask = m;
        waddr_0 = a0; waddr_1 = a1; waddr_2 = a2; waddr_3 = a3;
    endtask

    task automatic idle();
        issue = 1'b0;
        last  = 1'b0;
    endtask

    task automatic set_xy(input logic [13:0] a, input logic [13:0] b,
                          input logic [13:0] c, input logic [13:0] e);
        x0 = a; y0 = b; x1 = c; y1 = e;
    endtask

    initial begin
        rst = 1'b0;
        cmd(1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111, 8'd1, 8'd2, 8'd3, 8'd4);
        set_xy(14'd1, 14'd2, 14'd3, 14'd4);

        // Reset with issue held: nothing may be captured.
        step();
        step();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_d0", 32'(d0), 32'd0);
        chk("rst_d3", 32'(d3), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle();
        we_seen = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            we_seen |= we;
        end
        chk("rst_no_writes", 32'(we_seen), 32'd0);
        chk("rst_busy_after", 32'(busy), 32'd0);

        // Straight routing, latency BF_LAT+1.
        cmd(1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111, 8'd5, 8'd6, 8'd7, 8'd8);
        step();
        idle();
        chk("t2_busy_c1", 32'(busy), 32'd1);
        chk("t2_we_c1", 32'(we), 32'd0);
        step(); step(); step();
        chk("t2_we_c4", 32'(we), 32'd0);
        set_xy(14'd11, 14'd22, 14'd33, 14'd44);
        step();
        chk("t2_we", 32'(we), 32'hF);
        chk("t2_d0", 32'(d0), 32'd11);
        chk("t2_d1", 32'(d1), 32'd22);
        chk("t2_d2", 32'(d2), 32'd33);
        chk("t2_d3", 32'(d3), 32'd44);
        chk("t2_wa0", 32'(wa0), 32'd5);
        chk("t2_wa3", 32'(wa3), 32'd8);
        chk("t2_busy_c5", 32'(busy), 32'd1);
        step();
        chk("t2_we_off", 32'(we), 32'd0);
        chk("t2_d0_hold", 32'(d0), 32'd11);
        chk("t2_busy_c6", 32'(busy), 32'd0);

        // Crossed routing with a sparse mask; unmasked banks hold.
        cmd(1'b1, 1'b0, 2'd3, 2'd2, 2'd1, 2'd0, 4'b0101, 8'd9, 8'd10, 8'd11, 8'd12);
        set_xy(14'd0, 14'd0, 14'd0, 14'd0);
        step();
        idle();
        step(); step(); step();
        set_xy(14'd11, 14'd22, 14'd33, 14'd44);
        step();
        chk("t3_we", 32'(we), 32'h5);
        chk("t3_d0", 32'(d0), 32'd44);
        chk("t3_d2", 32'(d2), 32'd22);
        chk("t3_d1_hold", 32'(d1), 32'd22);
        chk("t3_d3_hold", 32'(d3), 32'd44);
        chk("t3_wa0", 32'(wa0), 32'd9);
        chk("t3_wa1_hold", 32'(wa1), 32'd6);
        chk("t3_wa2", 32'(wa2), 32'd11);
        chk("t3_wa3_hold", 32'(wa3), 32'd8);
        chk("t3_dup", 32'(dup_err), 32'd0);
        step(); step(); step();

        // Back-to-back burst of 8 with last on the final command.
        for (int c = 0; c <= 13; c++) begin
            chk($sformatf("t4_we_c%0d", c), 32'(we), (c >= 5 && c <= 12) ? 32'hF : 32'd0);
            chk($sformatf("t4_done_c%0d", c), 32'(stage_done), (c == 12) ? 32'd1 : 32'd0);
            chk($sformatf("t4_busy_c%0d", c), 32'(busy), (c >= 1 && c <= 12) ? 32'd1 : 32'd0);
            if (c >= 5 && c <= 12) begin
                chk($sformatf("t4_d0_c%0d", c), 32'(d0), 32'(100 + c - 1));
                chk($sformatf("t4_wa0_c%0d", c), 32'(wa0), 32'(c - 5));
            end
            if (c <= 7) begin
                cmd(1'b1, c == 7, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111,
                    8'(c), 8'd0, 8'd0, 8'd0);
            end else begin
                idle();
            end
            set_xy(14'(100 + c), 14'd0, 14'd0, 14'd0);
            step();
        end

        // Duplicate source on two enabled banks: sticky error.
        cmd(1'b1, 1'b0, 2'd1, 2'd1, 2'd2, 2'd3, 4'b0011, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        idle();
        step(); step(); step();
        chk("t5_dup_c4", 32'(dup_err), 32'd0);
        step();
        chk("t5_dup_c5", 32'(dup_err), 32'd1);
        chk("t5_we_c5", 32'(we), 32'h3);
        step(); step(); step();
        chk("t5_dup_sticky", 32'(dup_err), 32'd1);

        // Reset while commands are in flight discards them and clears the error.
        for (int c = 0; c < 3; c++) begin
            cmd(1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
            step();
        end
        chk("t6_busy_c3", 32'(busy), 32'd1);
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
        chk("t6_busy_c4", 32'(busy), 32'd0);
        chk("t6_dup_c4", 32'(dup_err), 32'd0);
        chk("t6_we_c4", 32'(we), 32'd0);
        we_seen = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            we_seen |= we;
        end
        chk("t6_no_writes", 32'(we_seen), 32'd0);

        // Same duplicate selects but only one bank enabled: no error.
        cmd(1'b1, 1'b0, 2'd1, 2'd1, 2'd2, 2'd3, 4'b0001, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        idle();
        step(); step(); step(); step();
        chk("t5b_we", 32'(we), 32'h1);
        chk("t5b_dup", 32'(dup_err), 32'd0);
        step(); step();
        chk("t5b_dup_later", 32'(dup_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
